// File: rtl/i2c_slave_rx_if.sv
// I2C target receiver bus bundle: raw SCL/SDA in, open-drain SDA enable,
// and the received-byte valid/ready handshake toward local logic.
interface i2c_slave_rx_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, rx_ready,
        output sda_oe, rx_data, rx_valid, start_det, stop_det, busy
    );

    modport master (
        output scl_i, sda_i, rx_ready,
        input  sda_oe, rx_data, rx_valid, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C write-only target: oversampled START/STOP detection, address match,
// byte shift-in with ACK/NAK, and valid/ready delivery of accepted bytes.
module i2c_slave_rx #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    i2c_slave_rx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_prev, sda_prev;
    logic scl, sda;
    logic scl_rise, scl_fall, start, stop;

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n, shifted;
    logic [3:0] bitcnt, bitcnt_n;
    logic       ack, ack_n;
    logic       phase, phase_n;
    logic       oe, oe_n;
    logic       busy, busy_n;
    logic [7:0] rx_data, rx_data_n;
    logic       rx_valid, rx_valid_n;
    logic       start_q, start_n;
    logic       stop_q, stop_n;
    logic       match;

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    // Bus conditions require SCL stable high across both samples.
    assign start    = scl & scl_prev & sda_prev & ~sda;
    assign stop     = scl & scl_prev & ~sda_prev & sda;
    assign shifted  = {shreg[6:0], sda};
    assign match    = (shifted[7:1] == ADDR) && !shifted[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            state    <= S_IDLE;
            shreg    <= 8'h00;
            bitcnt   <= 4'd0;
            ack      <= 1'b0;
            phase    <= 1'b0;
            oe       <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev <= scl;
            sda_prev <= sda;
            state    <= state_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            ack      <= ack_n;
            phase    <= phase_n;
            oe       <= oe_n;
            busy     <= busy_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            start_q  <= start_n;
            stop_q   <= stop_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bitcnt_n   = bitcnt;
        ack_n      = ack;
        phase_n    = phase;
        oe_n       = oe;
        busy_n     = busy;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        if (start) begin
            state_n  = S_ADDR;
            start_n  = 1'b1;
            busy_n   = 1'b0;
            bitcnt_n = 4'd0;
            oe_n     = 1'b0;
            phase_n  = 1'b0;
        end else if (stop) begin
            state_n = S_IDLE;
            stop_n  = 1'b1;
            busy_n  = 1'b0;
            oe_n    = 1'b0;
        end else begin
            unique case (state)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shreg_n  = shifted;
                        bitcnt_n = bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            phase_n = 1'b0;
                            if (state == S_ADDR) begin
                                ack_n   = match;
                                busy_n  = match;
                                state_n = S_ADDR_ACK;
                            end else begin
                                ack_n   = bus.rx_ready;
                                state_n = S_DATA_ACK;
                                if (bus.rx_ready) begin
                                    rx_data_n  = shifted;
                                    rx_valid_n = 1'b1;
                                end
                            end
                        end
                    end
                end
                // First fall opens the ACK slot, second fall closes it.
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_n    = ack;
                            phase_n = 1'b1;
                        end else begin
                            oe_n     = 1'b0;
                            bitcnt_n = 4'd0;
                            state_n  = ack ? S_DATA : S_IGNORE;
                        end
                    end
                end
                S_IDLE, S_IGNORE: oe_n = 1'b0;
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.sda_oe    = oe;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.busy      = busy;

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C target (slave) receiver. Sits directly downstream of the team's I2C master transmitter on the shared SCL/SDA bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit write address, shifts in data bytes and drives ACK/NAK open-drain.
- Hands each accepted byte to local logic over a valid/ready handshake.

Parameters:
- ADDR, 7'h50, 7-bit target address this block responds to.
- SYNC_STAGES, 2, number of flip-flops in each SCL/SDA input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rstn  in  1  reset; synchronous, active-low.
- scl_i  in  1  raw SCL bus level (asynchronous).
- sda_i  in  1  raw SDA bus level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release SDA.
- rx_data  out  8  last accepted data byte, MSB first on the bus.
- rx_valid  out  1  one-clk pulse when rx_data holds a newly accepted byte.
- rx_ready  in  1  consumer can take a byte; sampled at byte completion.
- start_det  out  1  one-clk pulse on START or repeated START.
- stop_det  out  1  one-clk pulse on STOP.
- busy  out  1  high from an address match (write direction) until STOP or repeated START.

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE; sda_oe=0, rx_valid=0, start_det=0, stop_det=0, busy=0, rx_data=8'h00, bit counter=0, synchronizer and edge registers=1 (idle bus).
- A reset mid-transaction releases SDA on the next clk edge.
- Input path:
  - SYNC_STAGES flip-flop synchronizer, then one previous-value register per line.
  - An edge is (prev != cur). Detection latency is SYNC_STAGES+1 clks.
- START: SDA falls while SCL is high (both current and previous SCL=1).
- STOP: SDA rises while SCL is high.
- START and STOP are detected in every state, including during reset release. They take priority over bit sampling in the same clk.
- Data bit: SDA is sampled on the SCL rising edge. The shift register is left-shifting; the first bit lands in the MSB.
- States:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits (7 address bits + R/W). On the 8th SCL rise:
    - If address==ADDR and R/W=0, ACK is set and busy=1.
    - Otherwise NAK is set.
    - Transition to ADDR_ACK.
  - ADDR_ACK:
    - On the first SCL fall, sda_oe=ACK.
    - On the next SCL fall, sda_oe=0. Then go to DATA if ACK, else IGNORE.
  - DATA: shift 8 bits. On the 8th SCL rise:
    - If rx_ready=1: load rx_data, pulse rx_valid for 1 clk, ACK.
    - If rx_ready=0: byte dropped, no rx_valid, NAK.
    - Transition to DATA_ACK.
  - DATA_ACK:
    - Same SCL-fall timing as ADDR_ACK.
    - After release, go to DATA if ACK, else IGNORE.
    - The master may STOP or repeated-START at any point.
  - IGNORE: sda_oe=0. Wait for START or STOP.
- Any state:
  - START -> ADDR, pulse start_det, busy=0, bit counter=0, sda_oe=0.
  - STOP -> IDLE, pulse stop_det, busy=0, sda_oe=0.
- Bit counter: 4 bits, 0..8, cleared at START and at each ACK-slot exit.
- The counter does not wrap inside a byte; an SCL rise seen while in an ACK state is not shifted.
- sda_oe changes only in the clk after a detected SCL fall (or on START/STOP/reset). It never changes while SCL is synchronized-high.
- General-call address 7'h00 is NAKed. Read requests (R/W=1) to ADDR are NAKed.
- rx_valid and start_det/stop_det are never asserted in the same clk as reset.

Test Plan:
- Reset with both lines idle high -> all outputs 0; no start_det or stop_det pulse after rstn rises.
- START, address 0x50+W, bytes 0xA5 and 0x3C, STOP, rx_ready=1 -> sda_oe ACKs 3 slots; rx_valid pulses twice with rx_data 0xA5 then 0x3C; stop_det 1 pulse; busy 1 then 0.
- START, address 0x51+W -> address slot NAK (sda_oe stays 0); following byte 0xFF produces no rx_valid; state IGNORE until STOP.
- Addressed write with rx_ready=0 at byte 0x12 -> NAK in that slot, no rx_valid; the next START+0x50+W is ACKed again.
- Repeated START after byte 0x77 (no STOP) -> start_det pulses, busy drops, new 0x50+W ACKed, subsequent 0x88 delivered.
- rstn asserted while sda_oe=1 in an ACK slot -> sda_oe=0 on the next clk; the block ignores bus traffic until a fresh START.
